mc6845_bus_sequencer: RTL and testbench

MC6845_BUS_SEQUENCER -- requirements
Module: mc6845_bus_sequencer

---
 rtl/mc6845_bus_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_mc6845_bus_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mc6845_bus_sequencer.sv
// MC6845 CRTC CPU-bus sequencer.
// Runs a table-driven init sequence (R0..R(NUM_REGS-1)) or single host
// register accesses, each as an address phase followed by a data phase
// with E-clock timing derived from the system clock.
module mc6845_bus_sequencer #(
    parameter int E_HALF   = 2,
    parameter int NUM_REGS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [4:0] tbl_addr,
    input  logic [7:0] tbl_data,
    input  logic       req,
    input  logic       req_wr,
    input  logic [4:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       ack,
    output logic       err,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       csn,
    output logic       e,
    output logic       rs,
    output logic       rw,
    output logic [7:0] d_out,
    output logic       d_oe,
    input  logic [7:0] d_in
);

    localparam int              CW       = (E_HALF > 1) ? $clog2(E_HALF) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(E_HALF - 1);
    localparam logic [4:0]      REG_LAST = 5'(NUM_REGS - 1);
    localparam logic [4:0]      REG_MAX  = 5'd17;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SETUP_A = 3'd1;
    localparam logic [2:0] EHI_A   = 3'd2;
    localparam logic [2:0] ELO_A   = 3'd3;
    localparam logic [2:0] SETUP_D = 3'd4;
    localparam logic [2:0] EHI_D   = 3'd5;
    localparam logic [2:0] ELO_D   = 3'd6;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          init_mode;
    logic [4:0]    idx;
    logic [4:0]    reg_q;
    logic          wr_q;
    logic [7:0]    wdata_q;

    logic          half_done;
    logic          addr_phase;
    logic          data_phase;
    logic [4:0]    cur_reg;
    logic          cur_wr;
    logic [7:0]    cur_wdata;

    assign half_done  = (cnt == CNT_LAST);
    assign addr_phase = (state == SETUP_A) || (state == EHI_A) || (state == ELO_A);
    assign data_phase = (state == SETUP_D) || (state == EHI_D) || (state == ELO_D);
    assign cur_reg    = init_mode ? idx : reg_q;
    assign cur_wr     = init_mode | wr_q;
    assign cur_wdata  = init_mode ? tbl_data : wdata_q;
    assign tbl_addr   = idx;

    // Sequencer state, phase timing, request capture and status pulses.
    // A host request is blocked in the ACK cycle (REQ is still held high
    // then) and in the reject cycle, so a single request is served once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            init_mode <= 1'b0;
            idx       <= '0;
            reg_q     <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            rdata     <= '0;
            ack       <= 1'b0;
            err       <= 1'b0;
            done      <= 1'b0;
        end else begin
            ack  <= 1'b0;
            err  <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !err) begin
                        init_mode <= 1'b1;
                        idx       <= '0;
                        state     <= SETUP_A;
                    end else if (req && !ack && !err) begin
                        if (req_reg > REG_MAX) begin
                            ack <= 1'b1;
                            err <= 1'b1;
                        end else begin
                            init_mode <= 1'b0;
                            reg_q     <= req_reg;
                            wr_q      <= req_wr;
                            wdata_q   <= req_wdata;
                            state     <= SETUP_A;
                        end
                    end
                end
                SETUP_A: begin
                    cnt   <= '0;
                    state <= EHI_A;
                end
                EHI_A: begin
                    if (half_done) begin
                        cnt   <= '0;
                        state <= ELO_A;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ELO_A: begin
                    if (half_done) begin
                        state <= SETUP_D;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SETUP_D: begin
                    cnt   <= '0;
                    state <= EHI_D;
                end
                EHI_D: begin
                    if (half_done) begin
                        if (!cur_wr) begin
                            rdata <= d_in;
                        end
                        cnt   <= '0;
                        state <= ELO_D;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ELO_D: begin
                    if (half_done) begin
                        if (init_mode) begin
                            if (idx == REG_LAST) begin
                                done      <= 1'b1;
                                idx       <= '0;
                                init_mode <= 1'b0;
                                state     <= IDLE;
                            end else begin
                                idx   <= idx + 1'b1;
                                state <= SETUP_A;
                            end
                        end else begin
                            ack   <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // CRTC bus controls decoded from the phase; they only move on phase entry.
    always_comb begin
        csn   = (state == IDLE);
        e     = (state == EHI_A) || (state == EHI_D);
        rs    = data_phase;
        rw    = 1'b1;
        d_oe  = 1'b0;
        d_out = '0;
        busy  = (state != IDLE) || err;
        if (addr_phase) begin
            rw    = 1'b0;
            d_oe  = 1'b1;
            d_out = {3'b000, cur_reg};
        end else if (data_phase) begin
            rw   = !cur_wr;
            d_oe = cur_wr;
            if (cur_wr) begin
                d_out = cur_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mc6845_bus_sequencer.sv
// Directed self-checking bench for mc6845_bus_sequencer (default parameters).
module tb_mc6845_bus_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, req, req_wr;
    logic [4:0] req_reg, tbl_addr;
    logic [7:0] req_wdata, tbl_data, rdata, d_out, d_in, din_val;
    logic       ack, err, busy, done, csn, e, rs, rw, d_oe;

    int checks   = 0;
    int failures = 0;

    // Per-transaction observations gathered by watch()
    logic [7:0] ad [32];
    logic       arw [32];
    logic       adoe [32];
    logic       ars [32];
    logic [7:0] dd [32];
    logic       drw [32];
    logic       ddoe [32];
    logic       drs [32];
    int         na, nd, ehi_cnt;
    logic       csn_gap, chg_viol;

    always #5 clk = ~clk;

    // Init table: TBL[i] = 0x40 + i
    assign tbl_data = 8'h40 + {3'b000, tbl_addr};
    // The CRTC drives D only while E is high in a read data phase
    assign d_in = (e && rs && rw) ? din_val : 8'hAA;

    mc6845_bus_sequencer #(.E_HALF(2), .NUM_REGS(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .req(req), .req_wr(req_wr), .req_reg(req_reg), .req_wdata(req_wdata),
        .ack(ack), .err(err), .rdata(rdata), .busy(busy), .done(done),
        .csn(csn), .e(e), .rs(rs), .rw(rw), .d_out(d_out), .d_oe(d_oe),
        .d_in(d_in)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until DONE or ACK; cyc counts cycles after the launch cycle.
    task automatic watch(input int cyc0, output int cyc, output logic got_done, output logic got_ack);
        logic pe, prs, prw, pdoe;
        logic [7:0] pdo;
        cyc = cyc0; got_done = 1'b0; got_ack = 1'b0;
        na = 0; nd = 0; ehi_cnt = 0; csn_gap = 1'b0; chg_viol = 1'b0;
        pe = e; prs = rs; prw = rw; pdoe = d_oe; pdo = d_out;
        while (!got_done && !got_ack && cyc < 400) begin
            tick();
            start = 1'b0;
            cyc++;
            if (done) got_done = 1'b1;
            if (ack) got_ack = 1'b1;
            if (!done && !ack && csn) csn_gap = 1'b1;
            if (e) ehi_cnt++;
            if (e && pe && (rs !== prs || rw !== prw || d_oe !== pdoe || d_out !== pdo))
                chg_viol = 1'b1;
            if (e && !pe) begin
                if (!rs && na < 32) begin
                    ad[na] = d_out; arw[na] = rw; adoe[na] = d_oe; ars[na] = rs; na++;
                end else if (rs && nd < 32) begin
                    dd[nd] = d_out; drw[nd] = rw; ddoe[nd] = d_oe; drs[nd] = rs; nd++;
                end
            end
            pe = e; prs = rs; prw = rw; pdoe = d_oe; pdo = d_out;
        end
    endtask

    initial begin
        int   cyc;
        logic gd, ga, seen;

        rst = 1'b1; start = 1'b0; req = 1'b0; req_wr = 1'b0;
        req_reg = '0; req_wdata = '0; din_val = 8'h00;
        tick(); tick();

        // Reset state
        check("rst_csn", csn, 1'b1);
        check("rst_e", e, 1'b0);
        check("rst_rs", rs, 1'b0);
        check("rst_rw", rw, 1'b1);
        check("rst_doe", d_oe, 1'b0);
        check("rst_dout", d_out, 8'h00);
        check("rst_tbladdr", tbl_addr, 5'd0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_ack", ack, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b0;
        tick();

        // Init sequence: 16 writes, DONE 161 cycles after START
        start = 1'b1;
        watch(0, cyc, gd, ga);
        check("init_done_seen", gd, 1'b1);
        check("init_done_cycle", cyc, 161);
        check("init_no_ack", ga, 1'b0);
        check("init_naddr", na, 16);
        check("init_ndata", nd, 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("init_reg%0d", i), ad[i], 8'(i));
            check($sformatf("init_data%0d", i), dd[i], 8'h40 + 8'(i));
        end
        check("init_data_rs_rw", {drs[15], drw[15], ddoe[15]}, 3'b101);
        check("init_ehi_cycles", ehi_cnt, 64);
        check("init_csn_held", csn_gap, 1'b0);
        check("init_stable_under_e", chg_viol, 1'b0);
        tick();
        check("done_one_cycle", done, 1'b0);

        // Write R14 = 0x3A; late changes to request fields and a START while busy are ignored
        req = 1'b1; req_wr = 1'b1; req_reg = 5'd14; req_wdata = 8'h3A;
        tick();
        check("wr_busy", busy, 1'b1);
        check("wr_csn", csn, 1'b0);
        req_wdata = 8'hFF; req_reg = 5'd3; req_wr = 1'b0; start = 1'b1;
        watch(1, cyc, gd, ga);
        check("wr_ack_cycle", cyc, 11);
        check("wr_ack_seen", ga, 1'b1);
        check("wr_err", err, 1'b0);
        check("wr_addr", {ars[0], arw[0], adoe[0], ad[0]}, {3'b001, 8'h0E});
        check("wr_data", {drs[0], drw[0], ddoe[0], dd[0]}, {3'b101, 8'h3A});
        check("wr_stable_under_e", chg_viol, 1'b0);
        req = 1'b0;
        tick();
        check("wr_start_ignored_csn", csn, 1'b1);
        check("wr_after_busy", busy, 1'b0);
        check("wr_ack_pulse", ack, 1'b0);
        check("wr_rdata_kept", rdata, 8'h00);

        // Read R16 with the CRTC returning 0x5C
        din_val = 8'h5C;
        req = 1'b1; req_wr = 1'b0; req_reg = 5'd16;
        watch(0, cyc, gd, ga);
        check("rd_ack_cycle", cyc, 11);
        check("rd_err", err, 1'b0);
        check("rd_rdata", rdata, 8'h5C);
        check("rd_addr", {ars[0], arw[0], adoe[0], ad[0]}, {3'b001, 8'h10});
        check("rd_data_ctl", {drs[0], drw[0], ddoe[0]}, 3'b110);
        req = 1'b0;
        tick();

        // Out-of-range register is rejected without bus activity
        req = 1'b1; req_wr = 1'b1; req_reg = 5'd20; req_wdata = 8'h11;
        tick();
        check("rej_ack", ack, 1'b1);
        check("rej_err", err, 1'b1);
        check("rej_busy", busy, 1'b1);
        check("rej_bus", {csn, e}, 2'b10);
        check("rej_rdata", rdata, 8'h5C);
        req = 1'b0;
        tick();
        check("rej_after", {ack, err, busy, csn}, 4'b0001);

        // START and REQ together: init first, request served after DONE
        start = 1'b1; req = 1'b1; req_wr = 1'b1; req_reg = 5'd3; req_wdata = 8'h77;
        watch(0, cyc, gd, ga);
        check("both_done_cycle", cyc, 161);
        check("both_no_ack_first", ga, 1'b0);
        watch(0, cyc, gd, ga);
        check("both_ack_cycle", cyc, 11);
        check("both_no_done_with_ack", gd, 1'b0);
        check("both_req_data", {ad[0], dd[0]}, {8'h03, 8'h77});
        req = 1'b0;
        tick();

        // Reset during EHI_D of the first init access
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (e && rs) seen = 1'b1;
            else tick();
        end
        check("rst_mid_reached_ehid", seen, 1'b1);
        rst = 1'b1;
        tick();
        check("rst_mid_bus", {csn, e, busy, rw, d_oe}, 5'b10010);
        check("rst_mid_tbladdr", tbl_addr, 5'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 170; i++) begin
            tick();
            if (done || ack || !csn) seen = 1'b1;
        end
        check("rst_mid_quiet", seen, 1'b0);
        start = 1'b1;
        watch(0, cyc, gd, ga);
        check("restart_done_cycle", cyc, 161);
        check("restart_first_reg", {ad[0], dd[0]}, {8'h00, 8'h40});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
